// File: rtl/apb_pkg.sv
// Shared types for the two-master APB arbiter: FSM state encoding, strobe width
// and the master index type.
package apb_pkg;

    localparam int APB_STB_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        TOUT   = 2'd3
    } apb_state_e;

    typedef logic [0:0] mst_idx_t;

endpackage

// File: rtl/apb_rr_pick.sv
// Two-way round-robin picker: a lone requester always wins, and under contention
// the master that did not own the most recent transfer wins.
module apb_rr_pick
    import apb_pkg::*;
(
    input  logic [1:0] req,
    input  mst_idx_t   last_grant,
    output logic       gnt_valid,
    output mst_idx_t   gnt_idx
);

    // Pick the next owner from the request vector and the previous owner
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        case (req)
            2'b01: begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b0;
            end
            2'b10: begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b1;
            end
            2'b11: begin
                gnt_valid = 1'b1;
                gnt_idx   = ~last_grant;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_idx   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/apb_arbiter.sv
// Two-master APB arbiter: captures the granted master's request, replays it as a
// clean SETUP/ACCESS sequence downstream and routes the response back to the owner.
module apb_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     APB_PRESETn,
    input  logic [ADDR_WIDTH-1:0]    m0_paddr,
    input  logic [DATA_WIDTH-1:0]    m0_pdata,
    input  logic                     m0_psel,
    input  logic                     m0_penable,
    input  logic                     m0_pwrite,
    input  logic [APB_STB_WIDTH-1:0] m0_pstb,
    output logic [DATA_WIDTH-1:0]    m0_prdata,
    output logic                     m0_pready,
    output logic                     m0_perr,
    input  logic [ADDR_WIDTH-1:0]    m1_paddr,
    input  logic [DATA_WIDTH-1:0]    m1_pdata,
    input  logic                     m1_psel,
    input  logic                     m1_penable,
    input  logic                     m1_pwrite,
    input  logic [APB_STB_WIDTH-1:0] m1_pstb,
    output logic [DATA_WIDTH-1:0]    m1_prdata,
    output logic                     m1_pready,
    output logic                     m1_perr,
    output logic [ADDR_WIDTH-1:0]    APB_paddr,
    output logic [DATA_WIDTH-1:0]    APB_pdata,
    output logic                     APB_psel,
    output logic                     APB_penable,
    output logic                     APB_pwrite,
    output logic [APB_STB_WIDTH-1:0] APB_pstb,
    input  logic [DATA_WIDTH-1:0]    APB_prdata,
    input  logic                     APB_pready,
    input  logic                     APB_perr,
    output logic                     grant_owner,
    output logic                     busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    apb_state_e       state_r;
    mst_idx_t         owner_r;
    mst_idx_t         last_grant_r;
    logic [CNT_W-1:0] cnt_r;
    logic             gnt_valid_s;
    mst_idx_t         gnt_idx_s;
    logic             unused_s;

    // The arbiter only needs psel as the request; penable is part of the master's own handshake
    assign unused_s = m0_penable ^ m1_penable;

    apb_rr_pick u_pick (
        .req        ({m1_psel, m0_psel}),
        .last_grant (last_grant_r),
        .gnt_valid  (gnt_valid_s),
        .gnt_idx    (gnt_idx_s)
    );

    // Transfer FSM, capture registers and ACCESS-phase watchdog
    always_ff @(posedge clk) begin
        if (!APB_PRESETn) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            cnt_r        <= '0;
            APB_paddr    <= '0;
            APB_pdata    <= '0;
            APB_psel     <= 1'b0;
            APB_penable  <= 1'b0;
            APB_pwrite   <= 1'b0;
            APB_pstb     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gnt_valid_s) begin
                        owner_r     <= gnt_idx_s;
                        APB_paddr   <= (gnt_idx_s == 1'b1) ? m1_paddr  : m0_paddr;
                        APB_pdata   <= (gnt_idx_s == 1'b1) ? m1_pdata  : m0_pdata;
                        APB_pwrite  <= (gnt_idx_s == 1'b1) ? m1_pwrite : m0_pwrite;
                        APB_pstb    <= (gnt_idx_s == 1'b1) ? m1_pstb   : m0_pstb;
                        APB_psel    <= 1'b1;
                        APB_penable <= 1'b0;
                        state_r     <= SETUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    APB_penable <= 1'b1;
                    cnt_r       <= '0;
                    state_r     <= ACCESS;
                end
                ACCESS: begin
                    if (APB_pready) begin
                        APB_psel     <= 1'b0;
                        APB_penable  <= 1'b0;
                        last_grant_r <= owner_r;
                        state_r      <= IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        // Slave never answered: drop the bus and answer the owner ourselves
                        APB_psel    <= 1'b0;
                        APB_penable <= 1'b0;
                        state_r     <= TOUT;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                TOUT: begin
                    last_grant_r <= owner_r;
                    state_r      <= IDLE;
                end
                default: begin
                    APB_psel    <= 1'b0;
                    APB_penable <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Route the completion only to the owner; everyone else sees all-zero responses
    always_comb begin
        m0_pready = 1'b0;
        m0_perr   = 1'b0;
        m0_prdata = '0;
        m1_pready = 1'b0;
        m1_perr   = 1'b0;
        m1_prdata = '0;
        if (APB_PRESETn && (state_r == ACCESS) && APB_pready) begin
            if (owner_r == 1'b0) begin
                m0_pready = 1'b1;
                m0_perr   = APB_perr;
                m0_prdata = APB_prdata;
            end else begin
                m1_pready = 1'b1;
                m1_perr   = APB_perr;
                m1_prdata = APB_prdata;
            end
        end else if (APB_PRESETn && (state_r == TOUT)) begin
            if (owner_r == 1'b0) begin
                m0_pready = 1'b1;
                m0_perr   = 1'b1;
            end else begin
                m1_pready = 1'b1;
                m1_perr   = 1'b1;
            end
        end else begin
            m0_pready = 1'b0;
            m1_pready = 1'b0;
        end
    end

    assign busy        = (state_r != IDLE);
    assign grant_owner = owner_r;

endmodule

// File: tb/tb_apb_arbiter.sv
// Scoreboard bench for apb_arbiter: expected transfers are queued when masters
// are driven and matched against the downstream bus and the master responses.
module tb_apb_arbiter;

    logic        clk;
    logic        APB_PRESETn;
    logic [31:0] m0_paddr, m0_pdata, m1_paddr, m1_pdata;
    logic        m0_psel, m0_penable, m0_pwrite, m1_psel, m1_penable, m1_pwrite;
    logic [3:0]  m0_pstb, m1_pstb;
    logic [31:0] m0_prdata, m1_prdata;
    logic        m0_pready, m0_perr, m1_pready, m1_perr;
    logic [31:0] APB_paddr, APB_pdata, APB_prdata;
    logic        APB_psel, APB_penable, APB_pwrite, APB_pready, APB_perr;
    logic [3:0]  APB_pstb;
    logic        grant_owner, busy;

    typedef struct {
        logic        own;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic [3:0]  stb;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        logic        tout;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   acc_n = 0;
    int   slv_wait = 0;
    logic slv_err = 1'b0;
    int   lat0, lat1;

    apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .APB_PRESETn(APB_PRESETn),
        .m0_paddr(m0_paddr), .m0_pdata(m0_pdata), .m0_psel(m0_psel), .m0_penable(m0_penable),
        .m0_pwrite(m0_pwrite), .m0_pstb(m0_pstb), .m0_prdata(m0_prdata), .m0_pready(m0_pready),
        .m0_perr(m0_perr),
        .m1_paddr(m1_paddr), .m1_pdata(m1_pdata), .m1_psel(m1_psel), .m1_penable(m1_penable),
        .m1_pwrite(m1_pwrite), .m1_pstb(m1_pstb), .m1_prdata(m1_prdata), .m1_pready(m1_pready),
        .m1_perr(m1_perr),
        .APB_paddr(APB_paddr), .APB_pdata(APB_pdata), .APB_psel(APB_psel), .APB_penable(APB_penable),
        .APB_pwrite(APB_pwrite), .APB_pstb(APB_pstb), .APB_prdata(APB_prdata),
        .APB_pready(APB_pready), .APB_perr(APB_perr),
        .grant_owner(grant_owner), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic own, input logic [31:0] addr, data, input logic wr,
                                    input logic [3:0] stb, input logic [31:0] rdata, input logic err,
                                    input int acc, input logic tout);
        exp_t e;
        e.own = own; e.addr = addr; e.data = data; e.wr = wr; e.stb = stb;
        e.rdata = rdata; e.err = err; e.acc = acc; e.tout = tout;
        return e;
    endfunction

    task automatic set_mst(input int m, input logic sel, en, input logic [31:0] addr, data,
                           input logic wr, input logic [3:0] stb);
        if (m == 0) begin
            m0_psel = sel; m0_penable = en; m0_paddr = addr; m0_pdata = data; m0_pwrite = wr; m0_pstb = stb;
        end else begin
            m1_psel = sel; m1_penable = en; m1_paddr = addr; m1_pdata = data; m1_pwrite = wr; m1_pstb = stb;
        end
    endtask

    // One APB transfer from master m; lat counts cycles from psel to the cycle showing pready
    task automatic mst_xfer(input int m, input logic [31:0] addr, data, input logic wr,
                            input logic [3:0] stb, input logic [31:0] chg_addr, input bit chg,
                            output int lat);
        bit          done;
        logic [31:0] cur;
        cur  = addr;
        done = 1'b0;
        lat  = 0;
        set_mst(m, 1'b1, 1'b0, cur, data, wr, stb);
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            done = (m == 0) ? m0_pready : m1_pready;
            @(posedge clk);
            #1;
            if (!done) begin
                if (chg && lat == 1) cur = chg_addr;
                set_mst(m, 1'b1, 1'b1, cur, data, wr, stb);
            end
        end
        if (!done) check_val("mst_wait_bound", 32'd0, 32'd1);
        set_mst(m, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'h0);
    endtask

    // Slave model: reads return the address, pready after slv_wait wait states
    initial begin
        int ws;
        ws = 0;
        APB_pready = 1'b0; APB_perr = 1'b0; APB_prdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (APB_psel && APB_penable) begin
                if (ws >= slv_wait) begin
                    APB_pready = 1'b1;
                    APB_perr   = slv_err;
                    APB_prdata = APB_pwrite ? 32'd0 : APB_paddr;
                end else begin
                    ws++;
                end
            end else begin
                ws = 0;
                APB_pready = 1'b0; APB_perr = 1'b0; APB_prdata = 32'd0;
            end
        end
    end

    // Monitor: downstream contents against queue front, responses pop the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (APB_psel && !APB_penable) acc_n = 0;
            if (APB_psel && APB_penable) begin
                acc_n++;
                check_val("busy_access", 32'(busy), 32'd1);
                check_val("rdy_fwd", 32'(m0_pready | m1_pready), 32'(APB_pready));
            end
            if (APB_psel) begin
                if (sb_q.size() > 0) begin
                    e = sb_q[0];
                    check_val("dn_paddr", APB_paddr, e.addr);
                    check_val("dn_pdata", APB_pdata, e.data);
                    check_val("dn_pwrite", 32'(APB_pwrite), 32'(e.wr));
                    check_val("dn_pstb", 32'(APB_pstb), 32'(e.stb));
                    check_val("dn_owner", 32'(grant_owner), 32'(e.own));
                end else if (!APB_penable) begin
                    check_val("sb_empty_setup", 32'd1, 32'd0);
                end
            end
            if (m0_pready || m1_pready) begin
                check_val("rsp_both", 32'(m0_pready & m1_pready), 32'd0);
                if (sb_q.size() == 0) begin
                    check_val("sb_empty_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("rsp_owner", 32'(m1_pready), 32'(e.own));
                    check_val("rsp_prdata", e.own ? m1_prdata : m0_prdata, e.rdata);
                    check_val("rsp_perr", 32'(e.own ? m1_perr : m0_perr), 32'(e.err));
                    check_val("rsp_other", (e.own ? m0_prdata : m1_prdata) | 32'(e.own ? m0_perr : m1_perr), 32'd0);
                    check_val("rsp_acc_cycles", 32'(acc_n), 32'(e.acc));
                    if (e.tout) check_val("tout_psel", 32'(APB_psel), 32'd0);
                end
            end else begin
                check_val("idle_out", m0_prdata | m1_prdata | 32'(m0_perr | m1_perr), 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_time_bound reached");
        $fatal(1);
    end

    initial begin
        APB_PRESETn = 1'b0;
        set_mst(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'h0);
        set_mst(1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_psel", 32'(APB_psel), 32'd0);
        check_val("rst_paddr", APB_paddr, 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_owner", 32'(grant_owner), 32'd0);
        @(posedge clk);
        #1;
        APB_PRESETn = 1'b1;

        // Single m0 write with an immediately-ready slave
        sb_q.push_back(mk_exp(1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 4'hF, 32'd0, 1'b0, 1, 1'b0));
        mst_xfer(0, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 4'hF, 32'd0, 1'b0, lat0);
        check_val("m0_latency", 32'(lat0), 32'd3);

        // m1 changes its address after grant; downstream keeps the captured one
        sb_q.push_back(mk_exp(1'b1, 32'h40, 32'h0, 1'b0, 4'h0, 32'h40, 1'b0, 1, 1'b0));
        mst_xfer(1, 32'h40, 32'h0, 1'b0, 4'h0, 32'h80, 1'b1, lat1);

        // Continuous contention: strict alternation starting with m0
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(mk_exp(1'b0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h100, 1'b0, 1, 1'b0));
            sb_q.push_back(mk_exp(1'b1, 32'h200, 32'h0, 1'b0, 4'h0, 32'h200, 1'b0, 1, 1'b0));
        end
        fork
            begin
                for (int k = 0; k < 4; k++) mst_xfer(0, 32'h100, 32'h0, 1'b0, 4'h0, 32'd0, 1'b0, lat0);
            end
            begin
                for (int k = 0; k < 4; k++) mst_xfer(1, 32'h200, 32'h0, 1'b0, 4'h0, 32'd0, 1'b0, lat1);
            end
        join

        // Five wait states then an error response
        slv_wait = 5; slv_err = 1'b1;
        sb_q.push_back(mk_exp(1'b0, 32'h300, 32'h1234, 1'b1, 4'h3, 32'd0, 1'b1, 6, 1'b0));
        mst_xfer(0, 32'h300, 32'h1234, 1'b1, 4'h3, 32'd0, 1'b0, lat0);
        slv_wait = 0; slv_err = 1'b0;

        // Watchdog: m1 times out, waiting m0 is served next
        slv_wait = 1000;
        sb_q.push_back(mk_exp(1'b1, 32'h400, 32'h0, 1'b0, 4'h0, 32'd0, 1'b1, 8, 1'b1));
        sb_q.push_back(mk_exp(1'b0, 32'h500, 32'h0, 1'b0, 4'h0, 32'h500, 1'b0, 1, 1'b0));
        fork
            mst_xfer(1, 32'h400, 32'h0, 1'b0, 4'h0, 32'd0, 1'b0, lat1);
            begin
                repeat (3) @(posedge clk);
                #1;
                mst_xfer(0, 32'h500, 32'h0, 1'b0, 4'h0, 32'd0, 1'b0, lat0);
            end
            begin
                for (int i = 0; i < 100 && !m1_pready; i++) @(negedge clk);
                slv_wait = 0;
            end
        join

        // Reset during ACCESS abandons the transfer
        slv_wait = 1000;
        sb_q.push_back(mk_exp(1'b0, 32'h600, 32'h0, 1'b0, 4'h0, 32'd0, 1'b0, 0, 1'b0));
        set_mst(0, 1'b1, 1'b0, 32'h600, 32'h0, 1'b0, 4'h0);
        for (int i = 0; i < 20 && !APB_penable; i++) @(negedge clk);
        check_val("reached_access", 32'(APB_penable), 32'd1);
        @(posedge clk);
        #1;
        APB_PRESETn = 1'b0;
        @(posedge clk);
        #1;
        set_mst(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'h0);
        check_val("rstm_psel", 32'(APB_psel), 32'd0);
        check_val("rstm_penable", 32'(APB_penable), 32'd0);
        check_val("rstm_paddr", APB_paddr, 32'd0);
        check_val("rstm_busy", 32'(busy), 32'd0);
        check_val("rstm_no_rdy", 32'(m0_pready), 32'd0);
        sb_q.delete();
        slv_wait = 0;
        @(posedge clk);
        #1;
        APB_PRESETn = 1'b1;

        // After reset, contention goes to m0 first
        sb_q.push_back(mk_exp(1'b0, 32'h700, 32'h0, 1'b0, 4'h0, 32'h700, 1'b0, 1, 1'b0));
        sb_q.push_back(mk_exp(1'b1, 32'h710, 32'h0, 1'b0, 4'h0, 32'h710, 1'b0, 1, 1'b0));
        fork
            mst_xfer(0, 32'h700, 32'h0, 1'b0, 4'h0, 32'd0, 1'b0, lat0);
            mst_xfer(1, 32'h710, 32'h0, 1'b0, 4'h0, 32'd0, 1'b0, lat1);
        join

        repeat (3) @(posedge clk);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
